rs_alu: RTL and testbench

RS_ALU -- requirements
Module: rs_alu

---
 rtl/rs_alu.sv | 161 ++++++++++++++++
 tb/tb_rs_alu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both operands arrive,
// then issues the lowest-index ready entry one cycle later.
package rs_alu_pkg;
    localparam int XLEN    = 32;
    localparam int PRF_LEN = 6;
    localparam int ROB_LEN = 5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
        ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_func_t;

    typedef struct packed {
        logic [XLEN-1:0]    opa_value;
        logic [XLEN-1:0]    opb_value;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
        alu_func_t          alu_func;
    } rs_alu_packet_t;
endpackage

module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_ALU_DEPTH = 8,
    parameter int RS_ALU_LEN   = $clog2(RS_ALU_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic               dispatch_valid,
    input  logic               dispatch_opa_ready,
    input  logic [XLEN-1:0]    dispatch_opa_value,
    input  logic [PRF_LEN-1:0] dispatch_opa_preg,
    input  logic               dispatch_opb_ready,
    input  logic [XLEN-1:0]    dispatch_opb_value,
    input  logic [PRF_LEN-1:0] dispatch_opb_preg,
    input  logic [PRF_LEN-1:0] dispatch_dest_preg_idx,
    input  logic [ROB_LEN-1:0] dispatch_rob_idx,
    input  logic [XLEN-1:0]    dispatch_PC,
    input  alu_func_t          dispatch_alu_func,
    input  logic               cdb_valid,
    input  logic [PRF_LEN-1:0] cdb_prf_idx,
    input  logic [XLEN-1:0]    cdb_value,
    output rs_alu_packet_t     rs_alu_packet,
    output logic               alu_enable,
    output logic               rs_alu_full
);

    typedef struct packed {
        logic               busy;
        logic               opa_ready;
        logic               opb_ready;
        logic [XLEN-1:0]    opa_value;
        logic [XLEN-1:0]    opb_value;
        logic [PRF_LEN-1:0] opa_preg;
        logic [PRF_LEN-1:0] opb_preg;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
        alu_func_t          alu_func;
    } rs_entry_t;

    rs_entry_t entries [RS_ALU_DEPTH];

    logic [RS_ALU_LEN-1:0]   free_idx;
    logic [RS_ALU_LEN-1:0]   issue_idx;
    logic                    issue_found;
    logic [RS_ALU_DEPTH-1:0] busy_vec;
    logic                    opa_rdy_in;
    logic                    opb_rdy_in;
    logic [XLEN-1:0]         opa_val_in;
    logic [XLEN-1:0]         opb_val_in;

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        free_idx    = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        busy_vec    = '0;
        for (int i = RS_ALU_DEPTH - 1; i >= 0; i--) begin
            busy_vec[i] = entries[i].busy;
            if (!entries[i].busy)
                free_idx = RS_ALU_LEN'(i);
            if (entries[i].busy && entries[i].opa_ready &&
                entries[i].opb_ready) begin
                issue_idx   = RS_ALU_LEN'(i);
                issue_found = 1'b1;
            end
        end
    end

    assign rs_alu_full = &busy_vec;

    // A tag broadcast in the dispatch cycle would otherwise be missed.
    always_comb begin
        opa_rdy_in = dispatch_opa_ready ||
                     (cdb_valid && cdb_prf_idx == dispatch_opa_preg);
        opb_rdy_in = dispatch_opb_ready ||
                     (cdb_valid && cdb_prf_idx == dispatch_opb_preg);
        opa_val_in = dispatch_opa_ready ? dispatch_opa_value : cdb_value;
        opb_val_in = dispatch_opb_ready ? dispatch_opb_value : cdb_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_ALU_DEPTH; i++)
                entries[i] <= '0;
            alu_enable    <= 1'b0;
            rs_alu_packet <= '0;
        end else if (squash) begin
            for (int i = 0; i < RS_ALU_DEPTH; i++)
                entries[i].busy <= 1'b0;
            alu_enable <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ALU_DEPTH; i++) begin
                if (cdb_valid && entries[i].busy) begin
                    if (!entries[i].opa_ready &&
                        entries[i].opa_preg == cdb_prf_idx) begin
                        entries[i].opa_ready <= 1'b1;
                        entries[i].opa_value <= cdb_value;
                    end
                    if (!entries[i].opb_ready &&
                        entries[i].opb_preg == cdb_prf_idx) begin
                        entries[i].opb_ready <= 1'b1;
                        entries[i].opb_value <= cdb_value;
                    end
                end
            end
            alu_enable <= issue_found;
            if (issue_found) begin
                rs_alu_packet <= '{
                    opa_value:     entries[issue_idx].opa_value,
                    opb_value:     entries[issue_idx].opb_value,
                    dest_preg_idx: entries[issue_idx].dest_preg_idx,
                    rob_idx:       entries[issue_idx].rob_idx,
                    pc:            entries[issue_idx].pc,
                    alu_func:      entries[issue_idx].alu_func
                };
                entries[issue_idx].busy <= 1'b0;
            end
            if (dispatch_valid && !rs_alu_full) begin
                entries[free_idx] <= '{
                    busy:          1'b1,
                    opa_ready:     opa_rdy_in,
                    opb_ready:     opb_rdy_in,
                    opa_value:     opa_val_in,
                    opb_value:     opb_val_in,
                    opa_preg:      dispatch_opa_preg,
                    opb_preg:      dispatch_opb_preg,
                    dest_preg_idx: dispatch_dest_preg_idx,
                    rob_idx:       dispatch_rob_idx,
                    pc:            dispatch_PC,
                    alu_func:      dispatch_alu_func
                };
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed dispatch/CDB vectors push expected
// issue packets with their issue cycle; a monitor pops on alu_enable.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               squash;
    logic               dispatch_valid;
    logic               dispatch_opa_ready;
    logic [XLEN-1:0]    dispatch_opa_value;
    logic [PRF_LEN-1:0] dispatch_opa_preg;
    logic               dispatch_opb_ready;
    logic [XLEN-1:0]    dispatch_opb_value;
    logic [PRF_LEN-1:0] dispatch_opb_preg;
    logic [PRF_LEN-1:0] dispatch_dest_preg_idx;
    logic [ROB_LEN-1:0] dispatch_rob_idx;
    logic [XLEN-1:0]    dispatch_PC;
    alu_func_t          dispatch_alu_func;
    logic               cdb_valid;
    logic [PRF_LEN-1:0] cdb_prf_idx;
    logic [XLEN-1:0]    cdb_value;
    rs_alu_packet_t     rs_alu_packet;
    logic               alu_enable;
    logic               rs_alu_full;

    rs_alu #(.RS_ALU_DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .dispatch_valid(dispatch_valid),
        .dispatch_opa_ready(dispatch_opa_ready),
        .dispatch_opa_value(dispatch_opa_value),
        .dispatch_opa_preg(dispatch_opa_preg),
        .dispatch_opb_ready(dispatch_opb_ready),
        .dispatch_opb_value(dispatch_opb_value),
        .dispatch_opb_preg(dispatch_opb_preg),
        .dispatch_dest_preg_idx(dispatch_dest_preg_idx),
        .dispatch_rob_idx(dispatch_rob_idx),
        .dispatch_PC(dispatch_PC),
        .dispatch_alu_func(dispatch_alu_func),
        .cdb_valid(cdb_valid),
        .cdb_prf_idx(cdb_prf_idx),
        .cdb_value(cdb_value),
        .rs_alu_packet(rs_alu_packet),
        .alu_enable(alu_enable),
        .rs_alu_full(rs_alu_full)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int             c;
        rs_alu_packet_t p;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic rs_alu_packet_t mk(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input alu_func_t f,
                                          input logic [4:0] rob);
        mk = '{opa_value: a, opb_value: b,
               dest_preg_idx: {1'b1, rob}, rob_idx: rob,
               pc: 32'h1000 + 32'({rob, 2'b00}), alu_func: f};
    endfunction

    task automatic expect_at(input int dly, input logic [31:0] a,
                             input logic [31:0] b, input alu_func_t f,
                             input logic [4:0] rob);
        exp_t e;
        e.c = cyc + dly;
        e.p = mk(a, b, f, rob);
        q.push_back(e);
    endtask

    task automatic clear_inputs();
        squash             = 1'b0;
        dispatch_valid     = 1'b0;
        dispatch_opa_ready = 1'b0;
        dispatch_opa_value = '0;
        dispatch_opa_preg  = '0;
        dispatch_opb_ready = 1'b0;
        dispatch_opb_value = '0;
        dispatch_opb_preg  = '0;
        dispatch_dest_preg_idx = '0;
        dispatch_rob_idx   = '0;
        dispatch_PC        = '0;
        dispatch_alu_func  = ALU_ADD;
        cdb_valid          = 1'b0;
        cdb_prf_idx        = '0;
        cdb_value          = '0;
    endtask

    task automatic tick();
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic dispatch(input logic ar, input logic [31:0] av,
                            input logic [5:0] at, input logic br,
                            input logic [31:0] bv, input logic [5:0] bt,
                            input alu_func_t f, input logic [4:0] rob);
        dispatch_valid         = 1'b1;
        dispatch_opa_ready     = ar;
        dispatch_opa_value     = av;
        dispatch_opa_preg      = at;
        dispatch_opb_ready     = br;
        dispatch_opb_value     = bv;
        dispatch_opb_preg      = bt;
        dispatch_dest_preg_idx = {1'b1, rob};
        dispatch_rob_idx       = rob;
        dispatch_PC            = 32'h1000 + 32'({rob, 2'b00});
        dispatch_alu_func      = f;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
        cdb_valid   = 1'b1;
        cdb_prf_idx = tag;
        cdb_value   = val;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].c < cyc) begin
                check("missed_issue", 128'(cyc), 128'(q[0].c));
                void'(q.pop_front());
            end
            if (alu_enable) begin
                if (q.size() == 0) begin
                    check("spurious_issue", 128'(alu_enable), 128'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("issue_cyc", 128'(cyc), 128'(e.c));
                    check("packet", 128'(rs_alu_packet), 128'(e.p));
                end
            end
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        dispatch(1'b1, 32'hdead, 6'd0, 1'b1, 32'd1, 6'd0, ALU_ADD, 5'd30);
        repeat (3) @(negedge clock);
        check("rst_enable", 128'(alu_enable), 128'(0));
        check("rst_full", 128'(rs_alu_full), 128'(0));
        check("rst_packet", 128'(rs_alu_packet), 128'(0));
        reset = 1'b0;
        clear_inputs();
        tick();

        // ready ADD, then back-to-back OR (dispatch + issue same edge)
        dispatch(1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, ALU_ADD, 5'd16);
        expect_at(2, 32'd5, 32'd7, ALU_ADD, 5'd16);
        tick();
        dispatch(1'b1, 32'hf0, 6'd0, 1'b1, 32'h0f, 6'd0, ALU_OR, 5'd17);
        expect_at(2, 32'hf0, 32'h0f, ALU_OR, 5'd17);
        tick();
        repeat (3) tick();

        // opa waits on tag 12
        dispatch(1'b0, 32'd0, 6'd12, 1'b1, 32'd2, 6'd0, ALU_SUB, 5'd18);
        tick();
        repeat (3) tick();
        cdb(6'd12, 32'h10);
        expect_at(2, 32'h10, 32'd2, ALU_SUB, 5'd18);
        tick();
        repeat (3) tick();

        // opb bypassed from same-cycle CDB
        dispatch(1'b1, 32'd4, 6'd0, 1'b0, 32'd0, 6'd9, ALU_AND, 5'd19);
        cdb(6'd9, 32'd3);
        expect_at(2, 32'd4, 32'd3, ALU_AND, 5'd19);
        tick();
        repeat (3) tick();

        // fill all 8; entries 2 and 5 share tag 30
        for (int i = 0; i < 8; i++) begin
            logic [5:0] tag;
            tag = (i == 2 || i == 5) ? 6'd30 : 6'(20 + i);
            dispatch(1'b0, 32'd0, tag, 1'b1, 32'(i), 6'd0,
                     ALU_XOR, 5'(i));
            tick();
            if (i == 6)
                check("full_at_7", 128'(rs_alu_full), 128'(0));
        end
        check("full_at_8", 128'(rs_alu_full), 128'(1));
        dispatch(1'b1, 32'd99, 6'd0, 1'b1, 32'd99, 6'd0, ALU_ADD, 5'd15);
        tick();
        check("full_after_9th", 128'(rs_alu_full), 128'(1));
        cdb(6'd23, 32'h33);
        expect_at(2, 32'h33, 32'd3, ALU_XOR, 5'd3);
        tick();
        check("full_on_wake", 128'(rs_alu_full), 128'(1));
        tick();
        check("full_after_issue", 128'(rs_alu_full), 128'(0));
        dispatch(1'b1, 32'h44, 6'd0, 1'b1, 32'h55, 6'd0, ALU_SLT, 5'd9);
        expect_at(2, 32'h44, 32'h55, ALU_SLT, 5'd9);
        tick();
        check("full_refill", 128'(rs_alu_full), 128'(1));
        repeat (3) tick();

        // entries 2 and 5 ready together
        cdb(6'd30, 32'h30);
        expect_at(2, 32'h30, 32'd2, ALU_XOR, 5'd2);
        expect_at(3, 32'h30, 32'd5, ALU_XOR, 5'd5);
        tick();
        repeat (4) tick();

        cdb(6'd27, 32'h27);
        expect_at(2, 32'h27, 32'd7, ALU_XOR, 5'd7);
        tick();
        repeat (3) tick();

        // entries 0,1,4,6 busy; entry 0 issuable when squash hits
        cdb(6'd20, 32'h20);
        tick();
        squash = 1'b1;
        dispatch(1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, ALU_ADD, 5'd21);
        tick();
        check("squash_enable", 128'(alu_enable), 128'(0));
        check("squash_full", 128'(rs_alu_full), 128'(0));
        tick();
        cdb(6'd21, 32'h21);
        tick();
        repeat (3) tick();

        dispatch(1'b1, 32'h123, 6'd0, 1'b1, 32'h321, 6'd0, ALU_SRA, 5'd20);
        expect_at(2, 32'h123, 32'h321, ALU_SRA, 5'd20);
        tick();
        repeat (3) tick();

        check("queue_empty", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
